// File: rtl/world_stream_decoder_if.sv
// ---------------------------------------------------------------------------
// world_stream_decoder_if
//   Bundles the byte input, the voxel write handshake and the debug counters
//   of world_stream_decoder into one interface.
//
//   Signals:
//     byte_in / byte_valid_in   received byte and its one-cycle qualifier
//     wr_x/y/z_out              voxel coordinate of the current write command
//     wr_block_out              block type of the current write command
//     wr_valid_out / wr_ready_in  write handshake towards the L3 cache
//     busy_out                  decoder is inside a packet or emitting
//     pkt_count_out             accepted packets (wraps)
//     err_count_out             errors seen (saturates at 255)
//     err_pulse_out             one-cycle strobe per error
//
//   Modports:
//     master  the decoder side (consumes bytes, drives write commands)
//     slave   the environment side (UART feed, cache port, LEDs)
// ---------------------------------------------------------------------------
interface world_stream_decoder_if #(
  parameter int LENGTH     = 64,
  parameter int WIDTH      = 64,
  parameter int HEIGHT     = 16,
  parameter int BLOCK_BITS = 5
);
  localparam int XW = $clog2(LENGTH);
  localparam int YW = $clog2(WIDTH);
  localparam int ZW = $clog2(HEIGHT);

  logic [7:0]            byte_in;
  logic                  byte_valid_in;
  logic [XW-1:0]         wr_x_out;
  logic [YW-1:0]         wr_y_out;
  logic [ZW-1:0]         wr_z_out;
  logic [BLOCK_BITS-1:0] wr_block_out;
  logic                  wr_valid_out;
  logic                  wr_ready_in;
  logic                  busy_out;
  logic [15:0]           pkt_count_out;
  logic [7:0]            err_count_out;
  logic                  err_pulse_out;

  modport master (
    input  byte_in, byte_valid_in, wr_ready_in,
    output wr_x_out, wr_y_out, wr_z_out, wr_block_out, wr_valid_out,
           busy_out, pkt_count_out, err_count_out, err_pulse_out
  );

  modport slave (
    output byte_in, byte_valid_in, wr_ready_in,
    input  wr_x_out, wr_y_out, wr_z_out, wr_block_out, wr_valid_out,
           busy_out, pkt_count_out, err_count_out, err_pulse_out
  );
endinterface

// File: rtl/world_stream_decoder.sv
// ---------------------------------------------------------------------------
// world_stream_decoder
//   Turns the server plugin's world-update byte stream (from uart_receiver)
//   into voxel write commands for the l3_cache write port.
//
//   Packets (byte order):
//     single : A5 x y z type chk
//     run    : 5A x y z type n chk      -> n+1 voxels, y fastest, then x, z
//   chk is the XOR of every byte after the header and before chk.
//   A packet is accepted only if chk matches and x/y/z/type are in range.
//   Bad checksum, out-of-range fields, an inter-byte gap of TIMEOUT_CYCLES
//   inside a packet, and any byte arriving while emitting all count as
//   errors.
//
//   Ports:
//     clk_in   single clock
//     rst_in   asynchronous active-high reset
//     bus      world_stream_decoder_if.master (bytes in, writes/counters out)
// ---------------------------------------------------------------------------
module world_stream_decoder #(
  parameter int LENGTH         = 64,
  parameter int WIDTH          = 64,
  parameter int HEIGHT         = 16,
  parameter int BLOCK_BITS     = 5,
  parameter int TIMEOUT_CYCLES = 4340
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  world_stream_decoder_if.master bus
);
  localparam int XW = $clog2(LENGTH);
  localparam int YW = $clog2(WIDTH);
  localparam int ZW = $clog2(HEIGHT);
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [GW-1:0] GAP_LAST   = GW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    HDR_SINGLE = 8'hA5;
  localparam logic [7:0]    HDR_RUN    = 8'h5A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_X,
    S_Y,
    S_Z,
    S_TYPE,
    S_CNT,
    S_CHK,
    S_EMIT
  } state_t;

  state_t                state;
  logic                  run_mode;

  // Raw packet fields are kept at full byte width so the range check sees
  // the whole value, not a truncated coordinate.
  logic [7:0]            x_b;
  logic [7:0]            y_b;
  logic [7:0]            z_b;
  logic [7:0]            t_b;
  logic [7:0]            n_b;
  logic [7:0]            chk_acc;
  logic [7:0]            rem;
  logic [GW-1:0]         gap;

  logic [XW-1:0]         wr_x;
  logic [YW-1:0]         wr_y;
  logic [ZW-1:0]         wr_z;
  logic [BLOCK_BITS-1:0] wr_blk;
  logic                  wr_valid;
  logic [15:0]           pkt_cnt;
  logic [7:0]            err_cnt;
  logic                  err_pulse;

  logic                  bv;
  logic                  in_pkt;
  logic                  timeout_hit;
  logic                  pkt_ok;
  logic                  chk_bad;
  logic                  overrun;
  logic                  err_evt;
  logic                  handshake;
  logic                  last_voxel;
  logic                  y_last;
  logic                  x_last;
  logic                  z_last;

  assign bv     = bus.byte_valid_in;
  assign in_pkt = (state inside {S_X, S_Y, S_Z, S_TYPE, S_CNT, S_CHK});

  // A byte in the expiry cycle takes priority: the timeout only fires when
  // no byte is present.
  assign timeout_hit = in_pkt && !bv && (gap == GAP_LAST);

  assign pkt_ok = (chk_acc == bus.byte_in)
               && (32'(x_b) < LENGTH)
               && (32'(y_b) < WIDTH)
               && (32'(z_b) < HEIGHT)
               && (32'(t_b) < (32'd1 << BLOCK_BITS));

  assign chk_bad    = (state == S_CHK) && bv && !pkt_ok;
  assign overrun    = (state == S_EMIT) && bv;
  assign err_evt    = timeout_hit || chk_bad || overrun;

  assign handshake  = wr_valid && bus.wr_ready_in;
  assign last_voxel = !run_mode || (rem == 8'd0);

  assign y_last = (wr_y == YW'(WIDTH - 1));
  assign x_last = (wr_x == XW'(LENGTH - 1));
  assign z_last = (wr_z == ZW'(HEIGHT - 1));

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= S_IDLE;
      run_mode  <= 1'b0;
      x_b       <= '0;
      y_b       <= '0;
      z_b       <= '0;
      t_b       <= '0;
      n_b       <= '0;
      chk_acc   <= '0;
      rem       <= '0;
      gap       <= '0;
      wr_x      <= '0;
      wr_y      <= '0;
      wr_z      <= '0;
      wr_blk    <= '0;
      wr_valid  <= 1'b0;
      pkt_cnt   <= '0;
      err_cnt   <= '0;
      err_pulse <= 1'b0;
    end else begin
      if (in_pkt && !bv) begin
        // Silent cycle inside a packet: run the gap counter, abandon the
        // partial packet when it expires.
        if (timeout_hit) begin
          state <= S_IDLE;
          gap   <= '0;
        end else begin
          gap <= gap + GW'(1);
        end
      end else begin
        gap <= '0;
        unique case (state)
          S_IDLE: begin
            // Anything other than a header byte is line noise.
            if (bv && (bus.byte_in == HDR_SINGLE || bus.byte_in == HDR_RUN)) begin
              run_mode <= (bus.byte_in == HDR_RUN);
              chk_acc  <= '0;
              state    <= S_X;
            end
          end
          // In the B_* states below a byte is guaranteed present.
          S_X: begin
            x_b     <= bus.byte_in;
            chk_acc <= chk_acc ^ bus.byte_in;
            state   <= S_Y;
          end
          S_Y: begin
            y_b     <= bus.byte_in;
            chk_acc <= chk_acc ^ bus.byte_in;
            state   <= S_Z;
          end
          S_Z: begin
            z_b     <= bus.byte_in;
            chk_acc <= chk_acc ^ bus.byte_in;
            state   <= S_TYPE;
          end
          S_TYPE: begin
            t_b     <= bus.byte_in;
            chk_acc <= chk_acc ^ bus.byte_in;
            state   <= run_mode ? S_CNT : S_CHK;
          end
          S_CNT: begin
            n_b     <= bus.byte_in;
            chk_acc <= chk_acc ^ bus.byte_in;
            state   <= S_CHK;
          end
          S_CHK: begin
            if (pkt_ok) begin
              wr_x     <= x_b[XW-1:0];
              wr_y     <= y_b[YW-1:0];
              wr_z     <= z_b[ZW-1:0];
              wr_blk   <= t_b[BLOCK_BITS-1:0];
              wr_valid <= 1'b1;
              rem      <= run_mode ? n_b : 8'd0;
              pkt_cnt  <= pkt_cnt + 16'd1;
              state    <= S_EMIT;
            end else begin
              state <= S_IDLE;
            end
          end
          S_EMIT: begin
            // Bytes here are dropped (flagged as overrun via err_evt).
            if (handshake) begin
              if (last_voxel) begin
                wr_valid <= 1'b0;
                state    <= S_IDLE;
              end else begin
                rem <= rem - 8'd1;
                // Raster order: y fastest, then x, then z, wrapping the
                // whole volume.
                if (y_last) begin
                  wr_y <= '0;
                  if (x_last) begin
                    wr_x <= '0;
                    wr_z <= z_last ? '0 : wr_z + ZW'(1);
                  end else begin
                    wr_x <= wr_x + XW'(1);
                  end
                end else begin
                  wr_y <= wr_y + YW'(1);
                end
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end

      err_pulse <= err_evt;
      if (err_evt && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  assign bus.wr_x_out      = wr_x;
  assign bus.wr_y_out      = wr_y;
  assign bus.wr_z_out      = wr_z;
  assign bus.wr_block_out  = wr_blk;
  assign bus.wr_valid_out  = wr_valid;
  assign bus.busy_out      = (state != S_IDLE);
  assign bus.pkt_count_out = pkt_cnt;
  assign bus.err_count_out = err_cnt;
  assign bus.err_pulse_out = err_pulse;
endmodule
